// File: rtl/icache_pkg.sv
// Shared types and widths for the direct-mapped instruction cache.
// Holds the refill FSM encoding and the saturating counter helper.
package icache_pkg;

   localparam int BLOCK_W      = 128;
   localparam int WORD_W       = 32;
   localparam int BLOCK_ADDR_W = 28;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_READ = 2'd1,
      WRITE    = 2'd2
   } state_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: synchronous write, asynchronous read, async valid clear.
// Tag and data carry no reset; only the valid bits are cleared.
module icache_line_store
   import icache_pkg::*;
#(
   parameter int NUM_LINES = 8,
   parameter int IDX_W     = 3,
   parameter int TAG_W     = 25
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               i_wr_en,
   input  logic [IDX_W-1:0]   i_wr_idx,
   input  logic [TAG_W-1:0]   i_wr_tag,
   input  logic [BLOCK_W-1:0] i_wr_data,
   input  logic [IDX_W-1:0]   i_rd_idx,
   output logic               o_rd_valid,
   output logic [TAG_W-1:0]   o_rd_tag,
   output logic [BLOCK_W-1:0] o_rd_data
);

   logic               r_valid [NUM_LINES];
   logic [TAG_W-1:0]   r_tag   [NUM_LINES];
   logic [BLOCK_W-1:0] r_data  [NUM_LINES];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            r_valid[i] <= 1'b0;
         end
      end else if (i_wr_en) begin
         r_valid[i_wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (i_wr_en) begin
         r_tag[i_wr_idx]  <= i_wr_tag;
         r_data[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_rd_valid = r_valid[i_rd_idx];
   assign o_rd_tag   = r_tag[i_rd_idx];
   assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only I-cache: 0-cycle combinational hit, stalls the CPU
// with cpu_busywait through a block refill (IDLE -> MEM_READ -> WRITE -> IDLE).
module instruction_cache
   import icache_pkg::*;
#(
   parameter int NUM_LINES = 8,
   parameter int IDX_W     = $clog2(NUM_LINES),
   parameter int TAG_W     = 28 - IDX_W
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    cpu_read,
   input  logic [31:0]             cpu_address,
   output logic [WORD_W-1:0]       cpu_instruction,
   output logic                    cpu_busywait,
   output logic                    mem_read,
   output logic [BLOCK_ADDR_W-1:0] mem_address,
   input  logic [BLOCK_W-1:0]      mem_readdata,
   input  logic                    mem_busywait,
   output logic [31:0]             hit_count,
   output logic [31:0]             miss_count
);

   state_t                  r_state;
   state_t                  w_next;
   logic [BLOCK_ADDR_W-1:0] r_blk_addr;
   logic [31:0]             r_hit_count;
   logic [31:0]             r_miss_count;

   logic [1:0]         w_off;
   logic [IDX_W-1:0]   w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic               w_rd_valid;
   logic [TAG_W-1:0]   w_rd_tag;
   logic [BLOCK_W-1:0] w_rd_data;
   logic               w_hit;
   logic               w_hit_inc;
   logic               w_miss_inc;
   logic               w_fill_en;
   logic               w_unused;

   assign w_off    = cpu_address[3:2];
   assign w_idx    = cpu_address[4+IDX_W-1:4];
   assign w_tag    = cpu_address[31:4+IDX_W];
   assign w_unused = ^cpu_address[1:0];

   // Refill targets the block latched on entry to MEM_READ, not the live PC.
   icache_line_store #(
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W)
   ) u_store (
      .clock      (clock),
      .reset      (reset),
      .i_wr_en    (w_fill_en),
      .i_wr_idx   (r_blk_addr[IDX_W-1:0]),
      .i_wr_tag   (r_blk_addr[BLOCK_ADDR_W-1:IDX_W]),
      .i_wr_data  (mem_readdata),
      .i_rd_idx   (w_idx),
      .o_rd_valid (w_rd_valid),
      .o_rd_tag   (w_rd_tag),
      .o_rd_data  (w_rd_data)
   );

   assign w_hit      = cpu_read && w_rd_valid && (w_rd_tag == w_tag);
   assign w_hit_inc  = (r_state == IDLE) && w_hit;
   assign w_miss_inc = (r_state == IDLE) && cpu_read && !w_hit;

   always_comb begin
      cpu_instruction = w_rd_data[31:0];
      case (w_off)
         2'd0:    cpu_instruction = w_rd_data[31:0];
         2'd1:    cpu_instruction = w_rd_data[63:32];
         2'd2:    cpu_instruction = w_rd_data[95:64];
         default: cpu_instruction = w_rd_data[127:96];
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (w_miss_inc)    w_next = MEM_READ;
         MEM_READ: if (!mem_busywait) w_next = WRITE;
         WRITE:    w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   always_comb begin
      cpu_busywait = 1'b0;
      mem_read     = 1'b0;
      mem_address  = cpu_address[31:4];
      w_fill_en    = 1'b0;
      case (r_state)
         IDLE: begin
            cpu_busywait = cpu_read && !w_hit;
         end
         MEM_READ: begin
            cpu_busywait = 1'b1;
            mem_read     = 1'b1;
            mem_address  = r_blk_addr;
         end
         WRITE: begin
            cpu_busywait = 1'b1;
            mem_address  = r_blk_addr;
            w_fill_en    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_blk_addr <= '0;
      end else if (w_miss_inc) begin
         r_blk_addr <= cpu_address[31:4];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         if (w_hit_inc)  r_hit_count  <= sat_inc(r_hit_count);
         if (w_miss_inc) r_miss_count <= sat_inc(r_miss_count);
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;

endmodule
